// File: rtl/riscv_pkg.sv
// Shared RISC-V constants used across the fetch front end.
// Latency: none (constants only).
// Backpressure: not applicable.
package riscv_pkg;

    // Default datapath width for address and instruction buses.
    localparam int XLEN_DEFAULT = 32;

    // Canonical NOP (ADDI x0,x0,0), used as the decode bubble instruction.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Default number of prefetch queue entries.
    localparam int FQ_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO holding fetched {pc, pc+4, instr} entries between imem and decode.
// Latency: an entry pushed on an edge is visible at pop_dat after that edge.
// Backpressure: push ignored while full, pop ignored while empty; flush empties in one edge.
module fetch_queue #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign pop_dat = mem_q[rd_ptr_q];

    // Pointer and occupancy update; flush wins over any push/pop in the same cycle.
    always_comb begin
        do_push  = push && !full && !flush;
        do_pop   = pop && !empty && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care until counted as valid, so no reset.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

endmodule

// File: rtl/fetch_queue_stage.sv
// Fetch stage: PC generation, one-cycle imem handshake, prefetch queue and decode register.
// Latency: request in cycle N -> queue at end of N+1 -> decode register at end of N+2.
// Backpressure: StallD holds decode and stops popping; fetch stops when queue + in-flight reach DEPTH.
module fetch_queue_stage
    import riscv_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter int              DEPTH    = FQ_DEPTH_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    input  logic            StallF,
    input  logic            StallD,
    input  logic            FlushD,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD
);

    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] instr;
    } fq_entry_t;

    localparam fq_entry_t BUBBLE = {{(2*XLEN){1'b0}}, XLEN'(NOP_INSTR)};

    // Fetch state
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            inflight_q, inflight_d;

    // Decode register
    fq_entry_t       dec_q, dec_d;
    logic            vld_q, vld_d;

    // Queue interface
    fq_entry_t       push_dat;
    fq_entry_t       head;
    logic            q_push, q_pop, q_flush;
    logic            q_full, q_empty;
    logic [CW-1:0]   q_count;

    logic [CW:0]     occupancy;
    logic            fetch_go;
    logic            resp_stale;
    logic            unused_target_lsbs;

    // Redirect targets are forced word-aligned, so the low bits never matter.
    assign unused_target_lsbs = &{1'b0, PCTargetE[1:0]};

    assign imem_req  = fetch_go;
    assign imem_addr = pc_q;
    assign InstrD    = dec_q.instr;
    assign PCD       = dec_q.pc;
    assign PCPlus4D  = dec_q.pc_plus4;
    assign ValidD    = vld_q;

    // PC and request generation; a redirect overrides StallF and suppresses the request.
    always_comb begin
        occupancy  = {1'b0, q_count} + {{CW{1'b0}}, inflight_q};
        fetch_go   = !StallF && !PCSrcE && (occupancy < (CW+1)'(DEPTH));
        pc_d       = pc_q;
        if (PCSrcE) begin
            pc_d = {PCTargetE[XLEN-1:2], 2'b00};
        end else if (fetch_go) begin
            pc_d = pc_q + XLEN'(4);
        end
        req_pc_d   = fetch_go ? pc_q : req_pc_q;
        inflight_d = fetch_go;
    end

    // Response capture. Data is only ever outstanding for one cycle, so the
    // redirect edge that makes a response stale is the same edge its data
    // arrives on: dropping the push there is what discards it.
    always_comb begin
        resp_stale        = PCSrcE;
        push_dat.pc       = req_pc_q;
        push_dat.pc_plus4 = req_pc_q + XLEN'(4);
        push_dat.instr    = imem_rdata;
        q_push            = inflight_q && !resp_stale && !q_full;
        q_flush           = PCSrcE;
        q_pop             = !StallD && !FlushD && !q_empty;
    end

    // Decode register: flush beats stall; an empty queue yields a bubble.
    always_comb begin
        dec_d = dec_q;
        vld_d = vld_q;
        if (FlushD) begin
            dec_d = BUBBLE;
            vld_d = 1'b0;
        end else if (!StallD) begin
            if (!q_empty) begin
                dec_d = head;
                vld_d = 1'b1;
            end else begin
                dec_d = BUBBLE;
                vld_d = 1'b0;
            end
        end
    end

    // Fetch and decode state; reset drops everything and restarts at RESET_PC.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q       <= RESET_PC;
            req_pc_q   <= RESET_PC;
            inflight_q <= 1'b0;
            dec_q      <= BUBBLE;
            vld_q      <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            dec_q      <= dec_d;
            vld_q      <= vld_d;
        end
    end

    fetch_queue #(
        .WIDTH ($bits(fq_entry_t)),
        .DEPTH (DEPTH)
    ) u_queue (
        .clock    (clock),
        .reset_n  (reset_n),
        .push     (q_push),
        .push_dat (push_dat),
        .pop      (q_pop),
        .flush    (q_flush),
        .pop_dat  (head),
        .full     (q_full),
        .empty    (q_empty),
        .count    (q_count)
    );

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Self-checking bench for fetch_queue_stage: imem returns addr>>2 one cycle after a request.
// Expected decode entries are queued from the bench's own PC model and popped on each decode load.
// Decode hold/bubble behaviour is checked against a bench-side model of the decode register.
module tb_fetch_queue_stage;

    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        PCSrcE = 1'b0;
    logic [31:0] PCTargetE = '0;
    logic        StallF = 1'b0;
    logic        StallD = 1'b0;
    logic        FlushD = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_q [$];
    logic [31:0] model_pc = RESET_PC;
    logic [31:0] dec_pc = '0, dec_p4 = '0, dec_instr = NOP;
    logic        dec_vld = 1'b0;

    always #5 clock = ~clock;

    // Instruction memory: data valid exactly one cycle after the request.
    always @(posedge clock) imem_rdata <= imem_req ? (imem_addr >> 2) : 32'hDEAD_BEEF;

    fetch_queue_stage #(
        .XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
    ) dut (
        .clock(clock), .reset_n(reset_n), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
    );

    task automatic model_reset();
        exp_q.delete();
        model_pc  = RESET_PC;
        dec_pc    = '0;
        dec_p4    = '0;
        dec_instr = NOP;
        dec_vld   = 1'b0;
    endtask

    // One clock cycle: check/record the request before the edge, check decode after it.
    task automatic step();
        logic        ld, fl;
        logic [31:0] e, e4;
        @(negedge clock);
        ld = !StallD && !FlushD;
        fl = FlushD;
        if (imem_req) begin
            checks++;
            if (imem_addr !== model_pc)
                $display("FAIL fetch_addr: got %h want %h", imem_addr, model_pc);
            if (imem_addr !== model_pc) errors++;
            exp_q.push_back(model_pc);
            model_pc = model_pc + 32'd4;
        end
        if (PCSrcE) begin
            exp_q.delete();
            model_pc = {PCTargetE[31:2], 2'b00};
        end
        @(posedge clock);
        #1;
        if (fl || (ld && ValidD !== 1'b1)) begin
            dec_pc = '0; dec_p4 = '0; dec_instr = NOP; dec_vld = 1'b0;
            checks++;
            if (ValidD !== 1'b0 || InstrD !== NOP || PCD !== 32'h0 || PCPlus4D !== 32'h0) begin
                errors++;
                $display("FAIL bubble: got v=%b i=%h pc=%h p4=%h want v=0 i=%h pc=0 p4=0",
                         ValidD, InstrD, PCD, PCPlus4D, NOP);
            end
        end else if (ld) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_instr: got pc=%h want no valid instruction", PCD);
            end else begin
                e  = exp_q.pop_front();
                e4 = e + 32'd4;
                dec_pc = e; dec_p4 = e4; dec_instr = e >> 2; dec_vld = 1'b1;
                if (PCD !== e || PCPlus4D !== e4 || InstrD !== (e >> 2)) begin
                    errors++;
                    $display("FAIL decode_seq: got pc=%h p4=%h i=%h want pc=%h p4=%h i=%h",
                             PCD, PCPlus4D, InstrD, e, e4, e >> 2);
                end
            end
        end else begin
            checks++;
            if (ValidD !== dec_vld || PCD !== dec_pc || PCPlus4D !== dec_p4 || InstrD !== dec_instr) begin
                errors++;
                $display("FAIL stall_hold: got v=%b pc=%h want v=%b pc=%h", ValidD, PCD, dec_vld, dec_pc);
            end
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (ValidD !== 1'b0 || InstrD !== NOP || PCD !== 32'h0 || PCPlus4D !== 32'h0) begin
            errors++;
            $display("FAIL reset_decode: got v=%b i=%h pc=%h p4=%h want bubble", ValidD, InstrD, PCD, PCPlus4D);
        end
        checks++;
        if (imem_addr !== RESET_PC) begin
            errors++;
            $display("FAIL reset_pc: got %h want %h", imem_addr, RESET_PC);
        end
        checks++;
        if (dut.u_queue.count !== 3'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d want 0", dut.u_queue.count);
        end
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_sequential();
        int n;
        int bubbles;
        n = 0;
        do begin
            step();
            n++;
        end while (ValidD !== 1'b1 && n < 20);
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL first_valid_latency: got %0d cycles want 3", n);
        end
        checks++;
        if (PCD !== 32'h0) begin
            errors++;
            $display("FAIL first_pcd: got %h want 00000000", PCD);
        end
        bubbles = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (ValidD !== 1'b1) bubbles++;
        end
        checks++;
        if (bubbles != 0) begin
            errors++;
            $display("FAIL throughput: got %0d bubbles want 0", bubbles);
        end
    endtask

    task automatic test_stall_d();
        int bubbles;
        StallD = 1'b1;
        repeat (6) step();
        checks++;
        if (dut.u_queue.count !== 3'(DEPTH)) begin
            errors++;
            $display("FAIL stall_queue_count: got %0d want %0d", dut.u_queue.count, DEPTH);
        end
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL stall_req_drop: got %b want 0", imem_req);
        end
        StallD = 1'b0;
        bubbles = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (ValidD !== 1'b1) bubbles++;
        end
        checks++;
        if (bubbles != 0) begin
            errors++;
            $display("FAIL stall_release_gap: got %0d bubbles want 0", bubbles);
        end
    endtask

    task automatic test_redirect();
        int n;
        checks++;
        if (dut.inflight_q !== 1'b1) begin
            errors++;
            $display("FAIL redirect_setup_inflight: got %b want 1", dut.inflight_q);
        end
        PCSrcE = 1'b1; FlushD = 1'b1; PCTargetE = 32'h0000_0103;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL redirect_no_req: got %b want 0", imem_req);
        end
        step();
        PCSrcE = 1'b0; FlushD = 1'b0;
        checks++;
        if (imem_addr !== 32'h0000_0100) begin
            errors++;
            $display("FAIL redirect_addr: got %h want 00000100", imem_addr);
        end
        n = 0;
        do begin
            step();
            n++;
        end while (ValidD !== 1'b1 && n < 20);
        checks++;
        if (ValidD !== 1'b1 || PCD !== 32'h0000_0100) begin
            errors++;
            $display("FAIL redirect_first_pcd: got v=%b pc=%h want v=1 pc=00000100", ValidD, PCD);
        end
        repeat (4) step();
    endtask

    task automatic test_stallf_redirect();
        PCSrcE = 1'b1; StallF = 1'b1; FlushD = 1'b1; PCTargetE = 32'h0000_0200;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL stallf_redirect_req: got %b want 0", imem_req);
        end
        step();
        PCSrcE = 1'b0; FlushD = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h0000_0200) begin
            errors++;
            $display("FAIL stallf_hold: got req=%b addr=%h want req=0 addr=00000200", imem_req, imem_addr);
        end
        step();
        StallF = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0200) begin
            errors++;
            $display("FAIL stallf_release: got req=%b addr=%h want req=1 addr=00000200", imem_req, imem_addr);
        end
        repeat (6) step();
    endtask

    task automatic test_wrap();
        logic        found;
        logic [31:0] p4;
        PCSrcE = 1'b1; FlushD = 1'b1; PCTargetE = 32'hFFFF_FFF8;
        step();
        PCSrcE = 1'b0; FlushD = 1'b0;
        step();
        step();
        checks++;
        if (imem_addr !== 32'h0000_0000) begin
            errors++;
            $display("FAIL wrap_addr: got %h want 00000000", imem_addr);
        end
        found = 1'b0;
        p4 = 32'hFFFF_FFFF;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (ValidD === 1'b1 && PCD === 32'hFFFF_FFFC) begin
                found = 1'b1;
                p4 = PCPlus4D;
            end
        end
        checks++;
        if (!found || p4 !== 32'h0000_0000) begin
            errors++;
            $display("FAIL wrap_pcplus4: got found=%b p4=%h want found=1 p4=00000000", found, p4);
        end
        repeat (4) step();
    endtask

    task automatic test_reset_midop();
        int valids;
        StallD = 1'b1;
        repeat (6) step();
        checks++;
        if (dut.u_queue.count !== 3'(DEPTH)) begin
            errors++;
            $display("FAIL midop_full: got %0d want %0d", dut.u_queue.count, DEPTH);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (ValidD !== 1'b0 || InstrD !== NOP || PCD !== 32'h0 || PCPlus4D !== 32'h0) begin
            errors++;
            $display("FAIL midop_async_bubble: got v=%b i=%h pc=%h want bubble", ValidD, InstrD, PCD);
        end
        checks++;
        if (dut.u_queue.count !== 3'd0 || imem_addr !== RESET_PC) begin
            errors++;
            $display("FAIL midop_clear: got count=%0d addr=%h want count=0 addr=%h",
                     dut.u_queue.count, imem_addr, RESET_PC);
        end
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        StallD  = 1'b0;
        model_reset();
        valids = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (ValidD === 1'b1) valids++;
        end
        checks++;
        if (valids != 8) begin
            errors++;
            $display("FAIL midop_restart: got %0d valid cycles want 8", valids);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall_d();
        test_redirect();
        test_stallf_redirect();
        test_wrap();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
